// File: rtl/adc_trig_capture.sv
// ADC front end: generates the ADC sample clock, registers samples into a
// circular buffer with pre-trigger history, triggers on a level crossing
// (or a forced trigger after a timeout) and freezes a trigger-aligned frame
// for readout.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start, buffer contents meaningless
//   S_PRE   | filling the pre-trigger history, triggers ignored
//   S_ARMED | ring keeps wrapping, looking for a crossing or timeout
//   S_POST  | writing the remainder of the frame after the trigger sample
//   S_DONE  | frame frozen and readable, start begins a new capture
module adc_trig_capture #(
   parameter int CLK_DIV   = 2,
   parameter int AW        = 10,
   parameter int DEPTH     = 1024,
   parameter int PRE_DEPTH = 256,
   parameter int TIMEOUT   = 4096
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [7:0]    ad_data,
   output logic          ad_clk,
   input  logic          start,
   input  logic [7:0]    trig_level,
   input  logic          trig_edge,
   output logic          busy,
   output logic          done,
   output logic          timed_out,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   localparam int DW       = $clog2(CLK_DIV);
   localparam int POST_LEN = DEPTH - PRE_DEPTH;              // includes trigger sample
   localparam int POST_LD  = (POST_LEN > 1) ? POST_LEN - 2 : 0;
   localparam int CW       = $clog2(TIMEOUT + DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div_cnt;
   logic          strobe;
   logic [7:0]    smp;
   logic          smp_vld;
   logic [7:0]    prev;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] start_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          cnt_zero;
   logic          edge_hit;
   logic          go;
   logic          wr_en;
   logic          ld_timeout;
   logic          ld_post;
   logic          latch_trig;
   logic [7:0]    mem [DEPTH];

   assign strobe   = (div_cnt == DW'(CLK_DIV - 1));
   assign cnt_zero = (cnt == '0);
   assign go       = start && ((state == S_IDLE) || (state == S_DONE));
   assign rd_ptr   = start_ptr + rd_addr;
   assign edge_hit = trig_edge ? ((prev > trig_level) && (smp <= trig_level))
                               : ((prev < trig_level) && (smp >= trig_level));

   // Free-running sample clock divider and sample register; smp_vld marks
   // the cycle in which a freshly captured sample is handed to the FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         ad_clk  <= 1'b0;
         smp     <= '0;
         smp_vld <= 1'b0;
      end else begin
         div_cnt <= strobe ? '0 : div_cnt + DW'(1);
         ad_clk  <= (div_cnt < DW'(CLK_DIV / 2));
         smp_vld <= strobe;
         if (strobe) smp <= ad_data;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode plus write/load strobes for the datapath.
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      done       = 1'b0;
      wr_en      = 1'b0;
      ld_timeout = 1'b0;
      ld_post    = 1'b0;
      latch_trig = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_PRE;
         end
         S_PRE: begin
            busy = 1'b1;
            if (smp_vld) begin
               wr_en = 1'b1;
               if (cnt_zero) begin
                  ld_timeout = 1'b1;
                  state_nxt  = S_ARMED;
               end
            end
         end
         S_ARMED: begin
            busy = 1'b1;
            if (smp_vld) begin
               wr_en = 1'b1;
               // cnt reaching zero means TIMEOUT samples went by untriggered
               if (edge_hit || cnt_zero) begin
                  latch_trig = 1'b1;
                  ld_post    = 1'b1;
                  state_nxt  = (POST_LEN > 1) ? S_POST : S_DONE;
               end
            end
         end
         S_POST: begin
            busy = 1'b1;
            if (smp_vld) begin
               wr_en = 1'b1;
               if (cnt_zero) state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_nxt = S_PRE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Write pointer, phase down-counter, trigger pointer and timeout flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         start_ptr <= '0;
         cnt       <= '0;
         prev      <= '0;
         timed_out <= 1'b0;
      end else if (go) begin
         wr_ptr    <= '0;
         cnt       <= CW'(PRE_DEPTH - 1);
         timed_out <= 1'b0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + AW'(1);
         prev   <= smp;
         if (ld_timeout)     cnt <= CW'(TIMEOUT);
         else if (ld_post)   cnt <= CW'(POST_LD);
         else if (!cnt_zero) cnt <= cnt - CW'(1);
         if (latch_trig) begin
            start_ptr <= wr_ptr - AW'(PRE_DEPTH);
            timed_out <= cnt_zero;
         end
      end
   end

   // Sample buffer write port; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= smp;
   end

   // Frame-relative synchronous read port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_data <= '0;
      else          rd_data <= mem[rd_ptr];
   end

endmodule

// File: tb/tb_adc_trig_capture.sv
// Bench for adc_trig_capture: stimulus streams are generated up front, a
// reference model derives the expected frame from the sample stream, and a
// scoreboard monitor checks read data one cycle after each read request.
module tb_adc_trig_capture;

   localparam int CLK_DIV   = 2;
   localparam int AW        = 10;
   localparam int DEPTH     = 1024;
   localparam int PRE_DEPTH = 256;
   localparam int TIMEOUT   = 4096;
   localparam int NGEN      = 6000;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [7:0]    ad_data = '0;
   logic          ad_clk;
   logic          start = 1'b0;
   logic [7:0]    trig_level = '0;
   logic          trig_edge = 1'b0;
   logic          busy;
   logic          done;
   logic          timed_out;
   logic [AW-1:0] rd_addr = '0;
   logic [7:0]    rd_data;

   adc_trig_capture #(
      .CLK_DIV(CLK_DIV), .AW(AW), .DEPTH(DEPTH),
      .PRE_DEPTH(PRE_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ad_data(ad_data), .ad_clk(ad_clk),
      .start(start), .trig_level(trig_level), .trig_edge(trig_edge),
      .busy(busy), .done(done), .timed_out(timed_out),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #10 clk = ~clk;

   typedef struct {int addr; int val;} rd_t;

   int  checks = 0;
   int  passed = 0;
   int  cyc = 0;
   int  g = 0;
   int  first_g = -1;
   int  last_g = -1;
   int  last_cyc = -1;
   int  exp_trig_j = 0;
   bit  exp_to = 1'b0;
   bit  pending_cap = 1'b0;
   bit  real_start = 1'b0;
   bit  rd_req = 1'b0;
   bit  mon_pend = 1'b0;
   int  gen [NGEN];
   int  exp_frame [DEPTH];
   int  act_frame [DEPTH];
   rd_t sbq [$];
   rd_t mon_e;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic check_cond(string name, bit ok, int act, string req);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, required %s", name, act, req);
   endtask

   // Expected frame from the sample stream: history, first qualifying
   // crossing after the pre-trigger fill (or the forced one), then the rest.
   function automatic void compute_model();
      int j;
      int p;
      int c;
      int lvl;
      lvl    = int'(trig_level);
      exp_to = 1'b0;
      for (j = PRE_DEPTH; j < PRE_DEPTH + TIMEOUT; j++) begin
         p = gen[first_g + j - 1];
         c = gen[first_g + j];
         if (trig_edge ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl)) break;
      end
      if (j == PRE_DEPTH + TIMEOUT) exp_to = 1'b1;
      exp_trig_j = j;
      for (int k = 0; k < DEPTH; k++) exp_frame[k] = gen[first_g + j - PRE_DEPTH + k];
      last_g = first_g + j + (DEPTH - PRE_DEPTH) - 1;
   endfunction

   // One clk cycle. The divider is free-running from reset release, so
   // edges numbered as multiples of CLK_DIV are the sample edges; the ADC
   // model presents the next stream value right after each sample edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      if (start && real_start) pending_cap = 1'b1;
      if (cyc % CLK_DIV == 0) begin
         if (pending_cap) begin
            first_g     = g;
            pending_cap = 1'b0;
            compute_model();
         end
         if (g == last_g) last_cyc = cyc;
         #1;
         g++;
         ad_data = 8'(gen[(g < NGEN) ? g : NGEN - 1]);
      end else begin
         #1;
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_timed_out", int'(timed_out), 0);
      check("rst_ad_clk", int'(ad_clk), 0);
      check("rst_rd_data", int'(rd_data), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n     = 1'b1;
      cyc         = 0;
      pending_cap = 1'b0;
      first_g     = -1;
      last_g      = -1;
   endtask

   task automatic restart_stream();
      g       = 0;
      ad_data = 8'(gen[0]);
   endtask

   task automatic fill_sine(int ph);
      for (int k = 0; k < NGEN; k++)
         gen[k] = int'($floor(128.0 + 127.0 *
                  $sin(2.0 * 3.14159265358979 * real'(k + ph) / 500.0) + 0.5));
      restart_stream();
   endtask

   task automatic fill_dc(int v);
      for (int k = 0; k < NGEN; k++) gen[k] = v;
      restart_stream();
   endtask

   task automatic fill_walk();
      int v;
      v = int'($urandom_range(195, 60));
      for (int k = 0; k < NGEN; k++) begin
         gen[k] = v;
         v = v + int'($urandom_range(6, 0)) - 3;
         if (v < 0) v = 0;
         if (v > 255) v = 255;
      end
      restart_stream();
   endtask

   task automatic issue_start();
      first_g    = -1;
      last_g     = -1;
      last_cyc   = -1;
      real_start = 1'b1;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      real_start = 1'b0;
   endtask

   // Runs one capture to completion; optionally pokes start mid-POST.
   task automatic run_capture(string tag, bit poke);
      int  done_cyc;
      bit  poked;
      done_cyc = -1;
      poked    = 1'b0;
      repeat ($urandom_range(7, 0)) tick();
      issue_start();
      for (int i = 0; i < 20000; i++) begin
         if (poke && !poked && first_g >= 0 && g == first_g + exp_trig_j + 100) begin
            check({tag, "_busy_in_post"}, int'(busy), 1);
            poked = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
         end else begin
            tick();
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      check_cond({tag, "_done_seen"}, done_cyc >= 0, done_cyc, "done within budget");
      if (done_cyc >= 0) begin
         check_cond({tag, "_done_time"},
                    done_cyc >= last_cyc && done_cyc <= last_cyc + 2 * CLK_DIV,
                    done_cyc - last_cyc, "0..2 samples after last sample");
         check({tag, "_timed_out"}, int'(timed_out), int'(exp_to));
         check({tag, "_busy_low"}, int'(busy), 0);
      end
   endtask

   task automatic read_frame(string tag, bit shuffle);
      int a;
      for (int k = 0; k < DEPTH; k++) begin
         a       = shuffle ? int'($urandom_range(DEPTH - 1, 0)) : k;
         rd_addr = AW'(a);
         rd_req  = 1'b1;
         sbq.push_back('{addr: a, val: exp_frame[a]});
         tick();
      end
      rd_req = 1'b0;
      tick();
      tick();
      check({tag, "_sb_drained"}, sbq.size(), 0);
   endtask

   // Monitor: read data is due one cycle after each request.
   always @(posedge clk) mon_pend <= rd_req;

   always @(negedge clk) begin
      if (mon_pend) begin
         if (sbq.size() == 0) begin
            check("sb_underflow", 0, 1);
         end else begin
            mon_e = sbq.pop_front();
            check($sformatf("rd_data[%0d]", mon_e.addr), int'(rd_data), mon_e.val);
            act_frame[mon_e.addr] = int'(rd_data);
         end
      end
   end

   initial begin
      int maxd;
      int d;
      #5;
      apply_reset();

      // Divider: ad_clk toggles each cycle, first high one cycle after release.
      for (int n = 1; n <= 20; n++) begin
         tick();
         check($sformatf("ad_clk_%0d", n), int'(ad_clk),
               int'(((n - 1) % CLK_DIV) < CLK_DIV / 2));
      end
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);

      // Rising trigger on sine.
      fill_sine(int'($urandom_range(499, 0)));
      trig_level = 8'd128;
      trig_edge  = 1'b0;
      run_capture("rise", 1'b0);
      read_frame("rise", 1'b0);
      check_cond("rise_pre", act_frame[PRE_DEPTH - 1] < 128, act_frame[PRE_DEPTH - 1], "<128");
      check_cond("rise_trig", act_frame[PRE_DEPTH] >= 128, act_frame[PRE_DEPTH], ">=128");
      maxd = 0;
      for (int k = 1; k < DEPTH; k++) begin
         d = act_frame[k] - act_frame[k - 1];
         if (d < 0) d = -d;
         if (d > maxd) maxd = d;
      end
      check_cond("rise_adjacent", maxd <= 4, maxd, "<=4");

      // Falling trigger, with a start pulse during POST that must be ignored.
      fill_sine(int'($urandom_range(499, 0)));
      trig_edge = 1'b1;
      run_capture("fall", 1'b1);
      read_frame("fall", 1'b0);
      check_cond("fall_pre", act_frame[PRE_DEPTH - 1] > 128, act_frame[PRE_DEPTH - 1], ">128");
      check_cond("fall_trig", act_frame[PRE_DEPTH] <= 128, act_frame[PRE_DEPTH], "<=128");

      // Forced trigger on DC input.
      fill_dc(100);
      trig_level = 8'd200;
      trig_edge  = 1'b0;
      run_capture("tmo", 1'b0);
      check("tmo_trig_index", exp_trig_j, PRE_DEPTH + TIMEOUT);
      read_frame("tmo", 1'b1);

      // Random walk with random level and edge, shuffled reads.
      fill_walk();
      trig_level = 8'($urandom_range(215, 40));
      trig_edge  = 1'($urandom_range(1, 0));
      run_capture("walk", 1'b0);
      read_frame("walk", 1'b1);

      // Reset in the middle of ARMED, then a fresh capture.
      fill_dc(100);
      trig_level = 8'd200;
      trig_edge  = 1'b0;
      issue_start();
      for (int i = 0; i < 4000; i++) begin
         if (first_g >= 0 && g >= first_g + 400) break;
         tick();
      end
      check("armed_busy", int'(busy), 1);
      apply_reset();
      fill_walk();
      trig_level = 8'($urandom_range(215, 40));
      trig_edge  = 1'($urandom_range(1, 0));
      run_capture("post_rst", 1'b0);
      read_frame("post_rst", 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/adc_trig_capture.md
Name: adc_trig_capture

Overview:
- Front-end stage directly behind the 8-bit parallel ADC (AD0 / AD0_CLK pins) inside top.
- Generates the ADC sample clock and registers each sample.
- Holds samples in a DEPTH-entry circular buffer with pre-trigger history and level/edge triggering (auto-trigger on timeout).
- Presents a frozen, trigger-aligned frame to downstream measurement logic through a synchronous read port.

Parameters:
- CLK_DIV, 2: clk cycles per ADC sample (even, >=2). Default gives 25 MS/s from 50 MHz.
- AW, 10: buffer address width.
- DEPTH, 1024: buffer entries; must equal 2**AW.
- PRE_DEPTH, 256: samples kept before the trigger sample; 1..DEPTH-1.
- TIMEOUT, 4096: samples spent in ARMED before a forced trigger.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- ad_data  in  8  ADC parallel data, unsigned offset binary (128 = 0 V)
- ad_clk  out  1  ADC sample clock
- start  in  1  one-cycle pulse; begins a capture
- trig_level  in  8  trigger threshold, unsigned
- trig_edge  in  1  0 = rising crossing, 1 = falling crossing
- busy  out  1  capture in progress
- done  out  1  frame valid and frozen
- timed_out  out  1  last frame was force-triggered
- rd_addr  in  AW  frame-relative read address, 0 = oldest sample
- rd_data  out  8  buffer read data

Behaviour:
- Reset values: ad_clk=0, busy=0, done=0, timed_out=0, rd_data=0; all counters, pointers and FSM cleared to IDLE.
- Clock divider:
  - div_cnt runs 0..CLK_DIV-1 continuously, in every state.
  - ad_clk is registered: high while div_cnt < CLK_DIV/2, low otherwise.
  - Internal sample strobe fires on the cycle div_cnt == CLK_DIV-1, i.e. mid-low phase; ad_data is registered into smp on that edge.
- FSM states: IDLE, PRE, ARMED, POST, DONE.
  - IDLE: start -> PRE; clear wr_ptr and counters; busy=1, done=0, timed_out=0.
  - PRE: write each strobed sample to mem[wr_ptr], wr_ptr++ mod DEPTH. After PRE_DEPTH writes -> ARMED. Triggers are ignored in PRE.
  - ARMED: keep writing (ring wraps). Trigger conditions, evaluated on each strobe using prev = last written sample and cur = current sample:
    - rising: prev < trig_level and cur >= trig_level
    - falling: prev > trig_level and cur <= trig_level
    - On trigger: write cur, latch start_ptr = (wr_ptr - PRE_DEPTH) mod DEPTH (cur's own address minus PRE_DEPTH), then go to POST.
    - If TIMEOUT samples pass without a trigger, the next sample is treated as the trigger and timed_out=1.
  - POST: write until DEPTH-PRE_DEPTH samples total have been written, counting the trigger sample -> DONE.
  - DONE: busy=0, done=1; no writes; buffer frozen. start -> restart, same actions as from IDLE, done drops the next cycle.
- Frame layout: rd_addr 0..PRE_DEPTH-1 are pre-trigger samples; rd_addr PRE_DEPTH is the trigger sample; the last address is the newest sample.
- Read port:
  - rd_data <= mem[(start_ptr + rd_addr) mod DEPTH], one clk latency, in every state.
  - Contents are only guaranteed while done=1.
- start is ignored while busy=1.
- Reset asserted mid-capture returns immediately to IDLE with the reset values above. Buffer contents are undefined afterwards.
- trig_level and trig_edge are sampled live; they must be held stable while busy=1.
- All pointer arithmetic is modulo DEPTH with no overflow flags. The divider never stops.

Test Plan:
- Clock check: CLK_DIV=2, release reset, observe 20 cycles -> ad_clk toggles every clk cycle, first rising edge 1 cycle after reset release, busy=0, done=0.
- Rising trigger on sine: 50 kHz sine, 127 amplitude, 128 offset, sampled on ad_clk; trig_level=128, trig_edge=0, pulse start.
  - done rises after >=1024 samples with timed_out=0.
  - rd_addr 255 returns a value <128; rd_addr 256 returns >=128.
  - Adjacent addresses differ by <=4 LSB.
- Falling trigger: same sine, trig_edge=1 -> rd_addr 255 returns >128 and rd_addr 256 returns <=128.
- Timeout: DC ad_data=100, trig_level=200, start.
  - done asserts after 256 + 4096 + 768 samples (±1 sample) with timed_out=1.
  - All 1024 reads return 100.
- Control and read timing:
  - start pulsed mid-POST -> no effect and frame completes normally.
  - Assert reset_n=0 during ARMED -> busy=0 and done=0 that same cycle; after release, a new start captures correctly.
  - Read timing: rd_addr stepped each cycle -> rd_data follows with exactly one cycle latency.
